// File: rtl/register_file_pkg.sv
// Shared widths, index/data types and the hardwired-zero index for the
// 24-bit CPU register file.
package regfile_pkg;

  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback bus for the register file: two source read ports and one
// destination write port. The datapath is the master, the register file the slave.
interface register_file_if;
  import regfile_pkg::*;

  reg_idx_t  Rs;
  reg_idx_t  Rt;
  reg_idx_t  Rd;
  reg_data_t WriteD;
  logic      RegWrite;
  reg_data_t ReadR1;
  reg_data_t ReadR2;

  modport master (
    output Rs, Rt, Rd, WriteD, RegWrite,
    input  ReadR1, ReadR2
  );

  modport slave (
    input  Rs, Rt, Rd, WriteD, RegWrite,
    output ReadR1, ReadR2
  );

endinterface

// File: rtl/register_file_read_port.sv
// Combinational read mux for one source operand.
// Build option: REGFILE_BYPASS_EN adds write-to-read forwarding so a value
// being written this cycle is visible before the committing edge.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t regs [NUM_REGS],
  input  reg_idx_t  addr,
  output reg_data_t data
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic      wrEn,
  input  reg_idx_t  wrIdx,
  input  reg_data_t wrData
`endif
);

`ifdef REGFILE_BYPASS_EN
  // Select stored value, overridden by in-flight write data on an index hit
  always_comb begin
    data = regs[addr];
    if (wrEn && (wrIdx != ZERO_REG) && (addr == wrIdx)) begin
      data = wrData;
    end
  end
`else
  // Select stored value only
  always_comb begin
    data = regs[addr];
  end
`endif

endmodule

// File: rtl/register_file.sv
// 16 x 24-bit register file: two combinational read ports, one synchronous
// write port, register 0 hardwired to zero, synchronous active-high reset.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding in the
// read ports.
module register_file
  import regfile_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  register_file_if.slave  bus
);

  // Register 0 has no storage; it only exists as a constant in the read view.
  reg_data_t mem [1:NUM_REGS-1];
  reg_data_t regView [NUM_REGS];

  // Commit writeback data on the rising edge; reset wins over a write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.RegWrite && (bus.Rd != ZERO_REG)) begin
      mem[bus.Rd] <= bus.WriteD;
    end
  end

  // Present storage plus the hardwired zero register as one indexable array
  always_comb begin
    regView[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regView[i] = mem[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwdEn;

  // Forwarding is only legal when the write will actually commit
  always_comb begin
    fwdEn = bus.RegWrite && !reset;
  end
`endif

  regfile_read_port u_readRs (
    .regs   (regView),
    .addr   (bus.Rs),
    .data   (bus.ReadR1)
`ifdef REGFILE_BYPASS_EN
    ,
    .wrEn   (fwdEn),
    .wrIdx  (bus.Rd),
    .wrData (bus.WriteD)
`endif
  );

  regfile_read_port u_readRt (
    .regs   (regView),
    .addr   (bus.Rt),
    .data   (bus.ReadR2)
`ifdef REGFILE_BYPASS_EN
    ,
    .wrEn   (fwdEn),
    .wrIdx  (bus.Rd),
    .wrData (bus.WriteD)
`endif
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default and
// REGFILE_BYPASS_EN builds).
module tb_register_file;
  import regfile_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  register_file_if rfBus ();

  register_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (rfBus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rfBus.Rs = 4'd3;
    rfBus.Rt = 4'd15;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h0) begin
      errors++;
      $display("FAIL reset_r1: got %h expected %h", rfBus.ReadR1, 24'h0);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'h0) begin
      errors++;
      $display("FAIL reset_r2: got %h expected %h", rfBus.ReadR2, 24'h0);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      rfBus.Rs = reg_idx_t'(i);
      #1;
      checks++;
      if (rfBus.ReadR1 !== 24'h0) begin
        errors++;
        $display("FAIL reset_all[%0d]: got %h expected %h", i, rfBus.ReadR1, 24'h0);
      end
    end
  endtask

  task automatic test_write_read();
    rfBus.RegWrite = 1'b1;
    rfBus.Rd = 4'd8;
    rfBus.WriteD = 24'd5;
    tick();
    rfBus.Rd = 4'd9;
    rfBus.WriteD = 24'd7;
    tick();
    rfBus.RegWrite = 1'b0;
    rfBus.Rs = 4'd8;
    rfBus.Rt = 4'd9;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'd5) begin
      errors++;
      $display("FAIL write_r8: got %h expected %h", rfBus.ReadR1, 24'd5);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'd7) begin
      errors++;
      $display("FAIL write_r9: got %h expected %h", rfBus.ReadR2, 24'd7);
    end
  endtask

  task automatic test_no_write();
    rfBus.RegWrite = 1'b0;
    rfBus.Rd = 4'd8;
    rfBus.WriteD = 24'hABCDEF;
    tick();
    rfBus.Rs = 4'd8;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'd5) begin
      errors++;
      $display("FAIL no_write_r8: got %h expected %h", rfBus.ReadR1, 24'd5);
    end
  endtask

  task automatic test_zero_reg();
    rfBus.RegWrite = 1'b1;
    rfBus.Rd = 4'd0;
    rfBus.WriteD = 24'hFFFFFF;
    tick();
    rfBus.RegWrite = 1'b0;
    rfBus.Rs = 4'd0;
    rfBus.Rt = 4'd0;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h0) begin
      errors++;
      $display("FAIL zero_r1: got %h expected %h", rfBus.ReadR1, 24'h0);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'h0) begin
      errors++;
      $display("FAIL zero_r2: got %h expected %h", rfBus.ReadR2, 24'h0);
    end
    rfBus.Rs = 4'd8;
    rfBus.Rt = 4'd9;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'd5 || rfBus.ReadR2 !== 24'd7) begin
      errors++;
      $display("FAIL zero_collateral: got %h/%h expected %h/%h",
               rfBus.ReadR1, rfBus.ReadR2, 24'd5, 24'd7);
    end
  endtask

  task automatic test_same_reg_and_reset();
    rfBus.RegWrite = 1'b1;
    rfBus.Rd = 4'd4;
    rfBus.WriteD = 24'h123456;
    tick();
    rfBus.RegWrite = 1'b0;
    rfBus.Rs = 4'd4;
    rfBus.Rt = 4'd4;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h123456) begin
      errors++;
      $display("FAIL same_reg_r1: got %h expected %h", rfBus.ReadR1, 24'h123456);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'h123456) begin
      errors++;
      $display("FAIL same_reg_r2: got %h expected %h", rfBus.ReadR2, 24'h123456);
    end
    // Write coinciding with reset: never forwarded, never committed
    reset = 1'b1;
    rfBus.RegWrite = 1'b1;
    rfBus.Rd = 4'd4;
    rfBus.WriteD = 24'd9;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h123456) begin
      errors++;
      $display("FAIL reset_no_fwd: got %h expected %h", rfBus.ReadR1, 24'h123456);
    end
    tick();
    reset = 1'b0;
    rfBus.RegWrite = 1'b0;
    rfBus.Rt = 4'd8;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h0) begin
      errors++;
      $display("FAIL reset_beats_write: got %h expected %h", rfBus.ReadR1, 24'h0);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'h0) begin
      errors++;
      $display("FAIL reset_clears_r8: got %h expected %h", rfBus.ReadR2, 24'h0);
    end
  endtask

  task automatic test_bypass();
    reg_data_t expPre;
    rfBus.RegWrite = 1'b1;
    rfBus.Rd = 4'd5;
    rfBus.WriteD = 24'h000111;
    tick();
    rfBus.Rs = 4'd5;
    rfBus.Rt = 4'd6;
    rfBus.Rd = 4'd5;
    rfBus.WriteD = 24'h00002A;
    rfBus.RegWrite = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    expPre = 24'h00002A;
`else
    expPre = 24'h000111;
`endif
    checks++;
    if (rfBus.ReadR1 !== expPre) begin
      errors++;
      $display("FAIL rdw_before_edge: got %h expected %h", rfBus.ReadR1, expPre);
    end
    checks++;
    if (rfBus.ReadR2 !== 24'h0) begin
      errors++;
      $display("FAIL rdw_other_port: got %h expected %h", rfBus.ReadR2, 24'h0);
    end
    tick();
    rfBus.RegWrite = 1'b0;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h00002A) begin
      errors++;
      $display("FAIL rdw_after_edge: got %h expected %h", rfBus.ReadR1, 24'h00002A);
    end
    // Write to R0 must never be forwarded
    rfBus.Rs = 4'd0;
    rfBus.Rd = 4'd0;
    rfBus.WriteD = 24'hFFFFFF;
    rfBus.RegWrite = 1'b1;
    #1;
    checks++;
    if (rfBus.ReadR1 !== 24'h0) begin
      errors++;
      $display("FAIL r0_no_fwd: got %h expected %h", rfBus.ReadR1, 24'h0);
    end
    tick();
    rfBus.RegWrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    reg_data_t exp1;
    reg_data_t exp2;
    rfBus.RegWrite = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      rfBus.Rd = reg_idx_t'(i);
      rfBus.WriteD = reg_data_t'(i * 24'h010101);
      tick();
    end
    // Unknown Rd with writes disabled must not disturb anything
    rfBus.RegWrite = 1'b0;
    rfBus.Rd = 'x;
    rfBus.WriteD = 'x;
    tick();
    for (int i = 0; i < NUM_REGS; i++) begin
      rfBus.Rs = reg_idx_t'(i);
      rfBus.Rt = reg_idx_t'(NUM_REGS - 1 - i);
      #1;
      exp1 = reg_data_t'(i * 24'h010101);
      exp2 = reg_data_t'((NUM_REGS - 1 - i) * 24'h010101);
      checks++;
      if (rfBus.ReadR1 !== exp1) begin
        errors++;
        $display("FAIL b2b_r1[%0d]: got %h expected %h", i, rfBus.ReadR1, exp1);
      end
      checks++;
      if (rfBus.ReadR2 !== exp2) begin
        errors++;
        $display("FAIL b2b_r2[%0d]: got %h expected %h", NUM_REGS - 1 - i, rfBus.ReadR2, exp2);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    rfBus.Rs = '0;
    rfBus.Rt = '0;
    rfBus.Rd = '0;
    rfBus.WriteD = '0;
    rfBus.RegWrite = 1'b0;
    test_reset();
    test_write_read();
    test_no_write();
    test_zero_reg();
    test_same_reg_and_reset();
    test_bypass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
